pipe_seq_ctrl: RTL

Run-control sequencer for the five-stage pipeline. It owns the instruction-memory program counter and the software load/run/step/halt modes. It redirects fetch on branches resolved in the MEM stage and produces the flush and bubble controls for the ID/EX and EX/MEM pipeline registers. It sits between the generic_regs software registers and the pipeline datapath, replacing free-running PC logic.

---
 rtl/pipe_seq_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipe_seq_ctrl.sv
// Run-control sequencer for the five-stage pipeline.
// Owns the fetch PC, load/run/step/halt modes, branch redirect and flush.
module pipe_seq_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter logic [ADDR_WIDTH-1:0] PC_LIMIT = 'h021,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_mode,
  input  logic                  run_cmd,
  input  logic                  step_cmd,
  input  logic                  halt_cmd,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  pipe_rst,
  output logic                  flush,
  output logic                  id_bubble,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state,
  output logic [31:0]           fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [7:0]              drain_q, drain_d;
  logic [31:0]             cnt_q, cnt_d;
  logic                    id_bubble_q, id_bubble_d;
  logic                    fetch_en;
  logic                    at_limit;

  assign fetch_en = (state_q == S_RUN) || (state_q == S_STEP);
  assign at_limit = (state_q == S_RUN) && (pc_q == PC_LIMIT);

  // A branch from a bubbled ID slot is wrong-path and never redirects.
  assign flush = !reset && !load_mode && !halt_cmd &&
                 fetch_en && br_taken && !id_bubble_q;

  assign done = !reset && !load_mode &&
                (state_q == S_DRAIN) && (drain_q == 8'd1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drain_d     = drain_q;
    cnt_d       = fetch_en ? cnt_q + 32'd1 : cnt_q;
    id_bubble_d = !(fetch_en && !flush);
    if (load_mode) begin
      state_d = S_LOAD;
      pc_d    = '0;
      drain_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run_cmd || step_cmd) begin
            state_d = run_cmd ? S_RUN : S_STEP;
            pc_d    = start_pc;
            cnt_d   = '0;
          end
        end
        S_RUN, S_STEP: begin
          if (flush) pc_d = br_target;
          else if (!halt_cmd && !at_limit) pc_d = pc_q + 1'b1;
          if (halt_cmd || state_q == S_STEP || (!flush && at_limit)) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
        S_DRAIN: begin
          drain_d = drain_q - 8'd1;
          if (drain_q <= 8'd1) state_d = S_IDLE;
        end
        S_LOAD: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      drain_q     <= '0;
      cnt_q       <= '0;
      id_bubble_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      id_bubble_q <= id_bubble_d;
    end
  end

  assign pc        = pc_q;
  assign state     = state_q;
  assign pipe_rst  = (state_q == S_LOAD);
  assign busy      = fetch_en || (state_q == S_DRAIN);
  assign id_bubble = id_bubble_q;
  assign fetch_cnt = cnt_q;

endmodule
